// File: rtl/gs_mem_arb.sv
// Two-requester arbiter for the shared row-matrix RAM: burst-locked ownership,
// drain of in-flight reads before handover, and owner-tagged read returns.
module gs_mem_arb #(
  parameter int k          = 4,
  parameter int l          = 4,
  parameter int READ_DELAY = 2,
  localparam int A         = (k > 1) ? $clog2(k) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic         rw0,
  input  logic         rw1,
  input  logic [l-1:0] wdata0,
  input  logic [l-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [l-1:0] rdata,
  output logic         mem_en,
  output logic [A-1:0] mem_addr,
  output logic         mem_rw,
  output logic [l-1:0] mem_din,
  input  logic [l-1:0] mem_dout,
  output logic         busy,
  output logic         viol
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, DRAIN = 2'd3} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [READ_DELAY:1] p_q, p_d;
  logic                pend_d;
  logic                acc_rd;
  logic                gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, busy_q;
  logic                viol_q, viol_d;
  logic [6:0]          cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                wait0, wait1, glitch0, glitch1;
  logic [A-1:0]        addr0_q, addr1_q;
  logic                rw0_q, rw1_q;

  // Memory mux follows the owner state directly
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_rw   = 1'b0;
    mem_din  = '0;
    case (state_q)
      OWN0: begin
        mem_en   = req0;
        mem_addr = addr0;
        mem_rw   = rw0 & req0;
        mem_din  = wdata0;
      end
      OWN1: begin
        mem_en   = req1;
        mem_addr = addr1;
        mem_rw   = rw1 & req1;
        mem_din  = wdata1;
      end
      default: ;
    endcase
  end

  assign acc_rd = mem_en & ~mem_rw;

  // p[i] marks a read strobed i cycles ago
  assign p_d[1] = acc_rd;
  for (genvar g = 2; g <= READ_DELAY; g++) begin : g_shift
    assign p_d[g] = p_q[g-1];
  end

  if (READ_DELAY > 1) begin : g_pend
    assign pend_d = |p_d[READ_DELAY-1:1];
  end else begin : g_nopend
    assign pend_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
          last_d  = ~last_q;
        end else if (req0) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0:    if (!req0) state_d = pend_d ? DRAIN : IDLE;
      OWN1:    if (!req1) state_d = pend_d ? DRAIN : IDLE;
      DRAIN:   if (!pend_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation counters saturate at 64: the 65th waiting cycle trips viol
  assign wait0   = req0 & ~gnt0_q;
  assign wait1   = req1 & ~gnt1_q;
  assign cnt0_d  = wait0 ? ((cnt0_q == 7'd64) ? cnt0_q : cnt0_q + 7'd1) : 7'd0;
  assign cnt1_d  = wait1 ? ((cnt1_q == 7'd64) ? cnt1_q : cnt1_q + 7'd1) : 7'd0;
  assign glitch0 = ~req0 & gnt0_q & ((rw0 != rw0_q) | (addr0 != addr0_q));
  assign glitch1 = ~req1 & gnt1_q & ((rw1 != rw1_q) | (addr1 != addr1_q));
  assign viol_d  = viol_q | (wait0 & (cnt0_q == 7'd64)) | (wait1 & (cnt1_q == 7'd64))
                 | glitch0 | glitch1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      p_q       <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
      viol_q    <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      p_q       <= p_d;
      gnt0_q    <= (state_d == OWN0);
      gnt1_q    <= (state_d == OWN1);
      rvalid0_q <= p_d[READ_DELAY] & ~last_d;
      rvalid1_q <= p_d[READ_DELAY] & last_d;
      busy_q    <= (state_d != IDLE);
      viol_q    <= viol_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  // Previous-cycle command fields, only consulted while a grant is held
  always_ff @(posedge clk) begin
    addr0_q <= addr0;
    addr1_q <= addr1;
    rw0_q   <= rw0;
    rw1_q   <= rw1;
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign busy    = busy_q;
  assign viol    = viol_q;
  assign rdata   = mem_dout;

endmodule
